dac_tx_channel: RTL
===================

// Module: dac_tx_channel
// PURPOSE
//  Transmit-side counterpart of the ADC receive channel: buffers 8-bit signed samples from the
//  fabric, paces them at a programmable rate, and applies gain/offset/clamp. Drives the DAC
//  sample bus. Sits between the sample source (DMA/generator) and the DAC pins; APB-configured.
// PARAMETERS
//  FIFO_DEPTH        16          sample FIFO depth, power of 2, 4..256
//  UNDERRUN_STRETCH  10000000    clocks the underrun output stays high after the last underrun
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  penable    in   1   APB enable
//  psel       in   1   APB select
//  paddr      in   32  APB address; paddr[4:2] selects the register
//  pwrite     in   1   APB write
//  pwdata     in   32  APB write data
//  prdata     out  32  APB read data, combinational from paddr; unmapped reads return 0
//  in         in   8   signed sample from the source
//  valid_in   in   1   in is valid
//  ready_in   out  1   = !fifo_full; a sample is accepted when valid_in && ready_in
//  out        out  8   signed sample to the DAC
//  valid_out  out  1   one-cycle pulse per output sample
//  underrun   out  1   stretched underrun indication
// BEHAVIOUR
//  - Reset: out=0, valid_out=0, underrun=0, FIFO empty, phase=0, all registers at defaults.
//    A reset asserted mid-operation clears everything in one cycle.
//  - Register write strobe: psel && penable && pwrite.
//  - Register map:
//      0x00 CTRL        [0] enable, [2:1] src (0=fifo, 1=const, 2=tone, 3=const);
//                       [3] clr_underrun (W1, self-clearing), [4] flush (W1, self-clearing)
//      0x04 GAIN        [15:0] signed Q8.8, reset 0x0100
//      0x08 OFFSET      [7:0] signed, reset 0
//      0x0C CONST       [7:0], reset 0
//      0x10 RATE        [15:0], reset 0
//      0x14 STATUS      RO: [0] underrun sticky, [1] empty, [2] full, [16:8] fifo level
//      0x18 URUN_COUNT  RO: 32-bit, saturates at 0xFFFFFFFF
//      0x1C TONE_STEP   [15:0]
//  - FIFO: accepts samples regardless of enable. Flush empties it in one cycle; a push in the
//    flush cycle is dropped. Full/empty are registered, so there is no push when full.
//  - Tick: when enable=1, a down-counter asserts tick and reloads RATE when it reaches 0.
//    Result: one tick every RATE+1 clocks; RATE=0 gives a tick every clock.
//    When enable=0 the counter is held at 0 and there are no ticks.
//  - Per tick, stage S0 selects raw:
//      src=0: pop FIFO if non-empty. If empty, this is an underrun: repeat the last raw, set
//             sticky, increment URUN_COUNT, and load the stretch counter with UNDERRUN_STRETCH.
//             A push in the same cycle as a pop from an empty FIFO is still an underrun.
//      src=1/3: CONST.   src=2: tone sample (see CONFIGURATION).
//  - S1: p = raw * GAIN (24-bit signed); s = (p >>> 8) + sext(OFFSET) (17-bit signed).
//  - S2: out = clamp(s, -128, 127); valid_out = 1.
//  - Latency: tick to valid_out is exactly 3 clocks. Fully pipelined, one sample per clock max.
//  - out holds its value between pulses. Clearing enable drains in-flight samples normally.
//  - GAIN/OFFSET/CONST/src changes take effect on the next tick entering the affected stage.
//  - clr_underrun clears sticky and URUN_COUNT. If it coincides with a new underrun, the new
//    underrun wins: sticky=1, count=1.
//  - underrun output = (stretch counter != 0); not affected by clr_underrun.
// CONFIGURATION
//  DAC_CHANNEL_TONE_EN defined:
//    - 16-bit phase accumulator; on each tick with src=2, raw = phase[15:8] (signed),
//      then phase += TONE_STEP (wraps mod 2^16). Produces a sawtooth.
//    - phase resets to 0 on reset or when enable goes 0->1.
//  DAC_CHANNEL_TONE_EN undefined:
//    - src=2 yields raw=0; TONE_STEP reads 0 and writes are ignored; no accumulator logic.
// TESTING
//  1 Reset defaults: read 0x04 -> 0x00000100; read 0x14 -> 0x2; out=0, valid_out=0, ready_in=1.
//  2 Passthrough: push 10, 20, -5; CTRL=0x1, RATE=0 -> out 10, 20, -5 on consecutive
//    valid_out pulses, first pulse 3 clocks after enable tick.
//  3 Clamp: GAIN=0x0200, OFFSET=0x10; samples 80, -100, 3 -> out 127, -128, 22.
//  4 Underrun: push 0x33, RATE=3, UNDERRUN_STRETCH=16, enable -> 0x33 every 4 clocks;
//    URUN_COUNT increments per tick, STATUS[0]=1, underrun=1. Write clr + disable -> count 0,
//    sticky 0, underrun falls 16 clocks after the last underrun.
//  5 Backpressure/flush: enable=0, drive 17 valid samples -> 16 accepted, ready_in=0,
//    level=16; write CTRL[4] -> level=0, ready_in=1 next clock.
//  6 Tone (with DAC_CHANNEL_TONE_EN): TONE_STEP=0x0100, src=2, enable -> out 0, 1, 2 ... 127,
//    -128, -127 ...; without the macro -> out constant 0 and TONE_STEP reads 0.

Source files
------------

// File: rtl/dac_tx_channel_if.sv
// dac_tx_channel_if
//   Bundles the APB register port and the sample stream ports of dac_tx_channel.
//   slave  : the channel (APB completer, sample sink, DAC driver)
//   master : the environment (APB requester, sample source, DAC observer)
//   APB      : psel, penable, pwrite, paddr[31:0], pwdata[31:0] -> prdata[31:0]
//   Samples  : in[7:0], valid_in -> ready_in
//   DAC side : out[7:0], valid_out, underrun
interface dac_tx_channel_if;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic signed [7:0] in;
    logic              valid_in;
    logic              ready_in;
    logic signed [7:0] out;
    logic              valid_out;
    logic              underrun;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, in, valid_in,
        output prdata, ready_in, out, valid_out, underrun
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, in, valid_in,
        input  prdata, ready_in, out, valid_out, underrun
    );
endinterface

// File: rtl/dac_tx_channel.sv
// dac_tx_channel
//   Transmit sample channel: FIFO-buffers signed 8-bit samples, releases them at a
//   programmable tick rate, applies Q8.8 gain, offset and saturation, and drives the DAC bus.
//   Optional sawtooth tone source is built when DAC_CHANNEL_TONE_EN is defined.
// Ports
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : dac_tx_channel_if.slave (APB registers, sample input, DAC output, underrun)
// Parameters
//   FIFO_DEPTH       : sample FIFO depth (power of 2, 4..256)
//   UNDERRUN_STRETCH : clocks the underrun output stays high after the last underrun
module dac_tx_channel #(
    parameter int FIFO_DEPTH       = 16,
    parameter int UNDERRUN_STRETCH = 10000000
) (
    input logic             clk,
    input logic             reset,
    dac_tx_channel_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(UNDERRUN_STRETCH + 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(UNDERRUN_STRETCH);

    typedef enum logic [1:0] {
        SRC_FIFO   = 2'd0,
        SRC_CONST  = 2'd1,
        SRC_TONE   = 2'd2,
        SRC_CONST2 = 2'd3
    } src_e;

    // ---------------- register interface ----------------
    logic [2:0] reg_sel;
    logic       wr, wr_ctrl, clr_urun, flush;

    assign reg_sel  = bus.paddr[4:2];
    assign wr       = bus.psel && bus.penable && bus.pwrite;
    assign wr_ctrl  = wr && (reg_sel == 3'd0);
    assign clr_urun = wr_ctrl && bus.pwdata[3];
    assign flush    = wr_ctrl && bus.pwdata[4];

    logic               enable_q;
    src_e               src_q;
    logic signed [15:0] gain_q;
    logic signed [7:0]  offset_q;
    logic [7:0]         const_q;
    logic [15:0]        rate_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= 1'b0;
            src_q    <= SRC_FIFO;
            gain_q   <= 16'sh0100;
            offset_q <= '0;
            const_q  <= '0;
            rate_q   <= '0;
        end else if (wr) begin
            case (reg_sel)
                3'd0: begin
                    enable_q <= bus.pwdata[0];
                    src_q    <= src_e'(bus.pwdata[2:1]);
                end
                3'd1:    gain_q   <= bus.pwdata[15:0];
                3'd2:    offset_q <= bus.pwdata[7:0];
                3'd3:    const_q  <= bus.pwdata[7:0];
                3'd4:    rate_q   <= bus.pwdata[15:0];
                default: ;
            endcase
        end
    end

    // ---------------- tick generator ----------------
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        tick;

    assign tick = enable_q && (tick_cnt_q == 16'd0);

    always_comb begin
        tick_cnt_d = tick_cnt_q - 16'd1;
        if (!enable_q) tick_cnt_d = '0;
        else if (tick) tick_cnt_d = rate_q;
    end

    always_ff @(posedge clk) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    // ---------------- sample FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, empty_q;
    logic          fifo_tick, push, pop, urun;

    assign fifo_tick = tick && (src_q == SRC_FIFO);
    // full/empty are registered, so push/pop never need to look at same-cycle traffic
    assign push      = bus.valid_in && !full_q && !flush;
    assign pop       = fifo_tick && !empty_q;
    assign urun      = fifo_tick && empty_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: ;
        endcase
        if (flush) level_d = '0;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            level_q <= level_d;
            full_q  <= (level_d == LW'(FIFO_DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    // ---------------- tone source ----------------
    logic [7:0]  tone_raw;
    logic [15:0] tone_step_rd;

`ifdef DAC_CHANNEL_TONE_EN
    logic [15:0] tone_step_q, phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        // restart the sawtooth whenever the channel is switched on
        if (wr_ctrl && bus.pwdata[0] && !enable_q) phase_d = '0;
        else if (tick && (src_q == SRC_TONE))      phase_d = phase_q + tone_step_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= '0;
            tone_step_q <= '0;
        end else begin
            phase_q <= phase_d;
            if (wr && (reg_sel == 3'd7)) tone_step_q <= bus.pwdata[15:0];
        end
    end

    assign tone_raw     = phase_q[15:8];
    assign tone_step_rd = tone_step_q;
`else
    assign tone_raw     = '0;
    assign tone_step_rd = '0;
`endif

    // ---------------- datapath S0 / S1 / S2 ----------------
    logic signed [7:0]  raw_q, raw_d;
    logic signed [23:0] prod;
    logic signed [16:0] sum, s_q;
    logic signed [7:0]  out_q, clamp;
    logic [2:0]         vld_q;

    always_comb begin
        raw_d = raw_q;
        case (src_q)
            SRC_FIFO: if (!empty_q) raw_d = mem_q[rd_ptr_q];  // underrun repeats last raw
            SRC_TONE: raw_d = tone_raw;
            default:  raw_d = const_q;
        endcase
    end

    assign prod = $signed({{16{raw_q[7]}}, raw_q}) * $signed({{8{gain_q[15]}}, gain_q});
    assign sum  = $signed({prod[23], prod[23:8]}) + $signed({{9{offset_q[7]}}, offset_q});

    always_comb begin
        clamp = s_q[7:0];
        if (!s_q[16] && (s_q[15:7] != 9'h000))     clamp = 8'sh7F;
        else if (s_q[16] && (s_q[15:7] != 9'h1FF)) clamp = 8'sh80;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q <= '0;
            s_q   <= '0;
            out_q <= '0;
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[1:0], tick};
            if (tick)     raw_q <= raw_d;
            if (vld_q[0]) s_q   <= sum;
            if (vld_q[1]) out_q <= clamp;
        end
    end

    // ---------------- underrun tracking ----------------
    logic          sticky_q;
    logic [31:0]   urun_cnt_q;
    logic [SW-1:0] stretch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q   <= 1'b0;
            urun_cnt_q <= '0;
            stretch_q  <= '0;
        end else begin
            // a new underrun beats a coincident clear
            if (urun) begin
                sticky_q   <= 1'b1;
                urun_cnt_q <= clr_urun ? 32'd1
                            : (urun_cnt_q == 32'hFFFF_FFFF) ? urun_cnt_q : urun_cnt_q + 32'd1;
                stretch_q  <= STRETCH_LOAD;
            end else begin
                if (clr_urun) begin
                    sticky_q   <= 1'b0;
                    urun_cnt_q <= '0;
                end
                if (stretch_q != '0) stretch_q <= stretch_q - SW'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    logic [31:0] status;

    always_comb begin
        status       = '0;
        status[0]    = sticky_q;
        status[1]    = empty_q;
        status[2]    = full_q;
        status[16:8] = 9'(level_q);
    end

    always_comb begin
        bus.prdata = '0;
        case (reg_sel)
            3'd0: bus.prdata = {29'b0, src_q, enable_q};
            3'd1: bus.prdata = {16'b0, gain_q};
            3'd2: bus.prdata = {24'b0, offset_q};
            3'd3: bus.prdata = {24'b0, const_q};
            3'd4: bus.prdata = {16'b0, rate_q};
            3'd5: bus.prdata = status;
            3'd6: bus.prdata = urun_cnt_q;
            3'd7: bus.prdata = {16'b0, tone_step_rd};
            default: ;
        endcase
    end

    assign bus.ready_in  = !full_q;
    assign bus.out       = out_q;
    assign bus.valid_out = vld_q[2];
    assign bus.underrun  = (stretch_q != '0);

    logic unused_bits;
    assign unused_bits = ^{bus.paddr[31:5], bus.paddr[1:0], bus.pwdata[31:16]};
endmodule
